// File: rtl/branch_ctrl.sv
// Branch resolution and redirect controller.
// Resolves EX-stage control transfers against the IF prediction, maintains a
// 2-bit saturating BHT for IF lookups, and sequences redirect plus flush on a
// mispredict.
module branch_ctrl #(
  parameter int unsigned BHT_ENTRIES  = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [4:0]       ex_branch_op,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FcLoad = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e           state_q;
  logic [FC_W-1:0]  flush_cnt_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic             flush_q;
  logic             busy_q;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic [1:0]       bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             is_jump;
  logic             is_cond;
  logic             resolve;
  logic             actual;
  logic             mispredict;

  assign if_idx     = if_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  // Reads the registered table, so a same-cycle update shows up next cycle.
  assign pred_taken = bht_q[if_idx][1];

  assign is_jump    = ex_branch_op[4];
  assign is_cond    = (ex_branch_op[4:3] == 2'b01);
  // Stalled instructions are re-presented; ones arriving in FLUSH are dead.
  assign resolve    = ex_valid & ~stall & (state_q == StIdle) & (ex_branch_op[4:3] != 2'b00);
  assign actual     = is_jump | ex_taken;
  assign mispredict = resolve & (actual != ex_pred_taken);

  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], ex_branch_op[2:0]};

  // BHT: saturating 2-bit counters, trained by conditional branches only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (resolve && is_cond) begin
      if (actual && (bht_q[ex_idx] != 2'b11)) begin
        bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
      end else if (!actual && (bht_q[ex_idx] != 2'b00)) begin
        bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
      end
    end
  end

  // Redirect/flush FSM with registered control outputs and mispredict count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      mispredict_cnt_q <= '0;
    end else begin
      // One-cycle pulse regardless of stall.
      redirect_valid_q <= mispredict;
      unique case (state_q)
        StIdle: begin
          if (mispredict) begin
            state_q       <= StFlush;
            flush_cnt_q   <= FcLoad;
            flush_q       <= 1'b1;
            busy_q        <= 1'b1;
            redirect_pc_q <= actual ? ex_target : (ex_pc + 32'd4);
            if (mispredict_cnt_q != {CNT_W{1'b1}}) begin
              mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
            end
          end
        end
        StFlush: begin
          // Stalled cycles do not count toward the flush window.
          if (!stall) begin
            if (flush_cnt_q == '0) begin
              state_q <= StIdle;
              flush_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              flush_cnt_q <= flush_cnt_q - FC_W'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign busy           = busy_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
